// File: rtl/pipe_subtractor_pkg.sv
// Shared types and constants for the pipelined subtractor.
// Provides default widths, the result flag bundle and the latency function.
package sub_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int TAG_W_DEF = 4;

    typedef struct packed {
        logic bo;
        logic ovf;
        logic zero;
        logic neg;
    } sub_flags_t;

    // The pipeline has an operand stage, log2(width) prefix levels
    // and a result stage.
    function automatic int sub_lat(input int width);
        return $clog2(width) + 2;
    endfunction

endpackage

// File: rtl/pipe_subtractor_if.sv
// Operand/result handshake bundle for pipe_subtractor.
// slave: in_valid/a/b/bi/in_tag/out_ready in; in_ready/out_valid/d/flags/out_tag out.
interface pipe_subtractor_if
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, a, b, bi, in_tag, out_ready,
        input  in_ready, out_valid, d, bo, ovf, zero, neg, out_tag
    );

    modport slave (
        input  in_valid, a, b, bi, in_tag, out_ready,
        output in_ready, out_valid, d, bo, ovf, zero, neg, out_tag
    );

endinterface

// File: rtl/pipe_subtractor_prefix_level.sv
// One registered parallel-prefix level combining (G,P) pairs at distance SPAN.
// Ports: clk, rstn, i_en (hold when 0), i_g/i_p in, o_g/o_p registered out.
module prefix_level #(
    parameter int WIDTH = 32,
    parameter int SPAN  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_p
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;

    // Positions below SPAN already hold their full prefix and pass through.
    always_comb begin
        w_g = i_g;
        w_p = i_p;
        for (int i = SPAN; i < WIDTH; i++) begin
            w_g[i] = i_g[i] | (i_p[i] & i_g[i-SPAN]);
            w_p[i] = i_p[i] & i_p[i-SPAN];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_g <= '0;
            r_p <= '0;
        end else if (i_en) begin
            r_g <= w_g;
            r_p <= w_p;
        end
    end

    assign o_g = r_g;
    assign o_p = r_p;

endmodule

// File: rtl/pipe_subtractor.sv
// Pipelined D = A - B - Bi on a prefix-carry adder fed with ~B and ~Bi.
// Ports: clk, rstn, bus (pipe_subtractor_if.slave). Macro PIPE_SUB_SAT_EN saturates on overflow.
module pipe_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    pipe_subtractor_if.slave bus
);

    localparam int LVL = $clog2(WIDTH);

    logic             w_adv;
    logic [WIDTH-1:0] w_g [LVL+1];
    logic [WIDTH-1:0] w_p [LVL+1];
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_d;
    logic             w_ovf;
    sub_flags_t       w_flags;

    logic [WIDTH-1:0] r_g0;
    logic [WIDTH-1:0] r_p1  [LVL+1];
    logic             r_c0  [LVL+1];
    logic             r_sa  [LVL+1];
    logic             r_sb  [LVL+1];
    logic [TAG_W-1:0] r_tag [LVL+1];
    logic             r_vld [LVL+1];

    logic [WIDTH-1:0] r_d;
    sub_flags_t       r_flags;
    logic [TAG_W-1:0] r_otag;
    logic             r_ovld;

    // Whole pipe moves in lockstep; an empty output slot also frees it.
    assign w_adv       = bus.out_ready | ~r_ovld;
    assign bus.in_ready = w_adv;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_g0 <= '0;
            for (int k = 0; k <= LVL; k++) begin
                r_p1[k]  <= '0;
                r_c0[k]  <= 1'b0;
                r_sa[k]  <= 1'b0;
                r_sb[k]  <= 1'b0;
                r_tag[k] <= '0;
                r_vld[k] <= 1'b0;
            end
        end else if (w_adv) begin
            r_g0     <= bus.a & ~bus.b;
            r_p1[0]  <= bus.a ^ ~bus.b;
            r_c0[0]  <= ~bus.bi;
            r_sa[0]  <= bus.a[WIDTH-1];
            r_sb[0]  <= bus.b[WIDTH-1];
            r_tag[0] <= bus.in_tag;
            r_vld[0] <= bus.in_valid;
            for (int k = 1; k <= LVL; k++) begin
                r_p1[k]  <= r_p1[k-1];
                r_c0[k]  <= r_c0[k-1];
                r_sa[k]  <= r_sa[k-1];
                r_sb[k]  <= r_sb[k-1];
                r_tag[k] <= r_tag[k-1];
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign w_g[0] = r_g0;
    assign w_p[0] = r_p1[0];

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (1 << k)
        ) u_lvl (
            .clk  (clk),
            .rstn (rstn),
            .i_en (w_adv),
            .i_g  (w_g[k]),
            .i_p  (w_p[k]),
            .o_g  (w_g[k+1]),
            .o_p  (w_p[k+1])
        );
    end

    // w_g/w_p[LVL][i] are group terms over bits i..0, so carry i+1 needs c0.
    assign w_c   = {w_g[LVL] | (w_p[LVL] & {WIDTH{r_c0[LVL]}}), r_c0[LVL]};
    assign w_raw = r_p1[LVL] ^ w_c[WIDTH-1:0];
    assign w_ovf = (r_sa[LVL] ^ r_sb[LVL]) & (w_raw[WIDTH-1] ^ r_sa[LVL]);

`ifdef PIPE_SUB_SAT_EN
    // Overflow direction follows the minuend sign.
    assign w_d = w_ovf ? {r_sa[LVL], {(WIDTH-1){~r_sa[LVL]}}} : w_raw;
`else
    assign w_d = w_raw;
`endif

    always_comb begin
        w_flags      = '0;
        w_flags.bo   = ~w_c[WIDTH];
        w_flags.ovf  = w_ovf;
        w_flags.zero = (w_d == '0);
        w_flags.neg  = w_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_d     <= '0;
            r_flags <= '0;
            r_otag  <= '0;
            r_ovld  <= 1'b0;
        end else if (w_adv) begin
            r_d     <= w_d;
            r_flags <= w_flags;
            r_otag  <= r_tag[LVL];
            r_ovld  <= r_vld[LVL];
        end
    end

    assign bus.out_valid = r_ovld;
    assign bus.d         = r_d;
    assign bus.bo        = r_flags.bo;
    assign bus.ovf       = r_flags.ovf;
    assign bus.zero      = r_flags.zero;
    assign bus.neg       = r_flags.neg;
    assign bus.out_tag   = r_otag;

endmodule

// File: tb/tb_pipe_subtractor.sv
// Self-checking bench for pipe_subtractor (WIDTH=32, TAG_W=4).
// Directed cases, random stalled stream, and reset with beats in flight.
module tb_pipe_subtractor;

    localparam int W   = 32;
    localparam int LAT = 7;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ovf;
        logic         zero;
        logic         neg;
        logic [3:0]   tag;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;

    pipe_subtractor_if #(.WIDTH(W), .TAG_W(4)) bus ();

    pipe_subtractor #(.WIDTH(W), .TAG_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         got_n = 0;
    bit         acc;
    exp_t       exp_q[$];
    logic [W-1:0] last_d;
    logic [3:0] last_fl;
    logic [3:0] last_tag;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bi, input logic [3:0] tag);
        exp_t   e;
        longint sa, sb, r, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b) + longint'(bi);
        r  = sa - sb - longint'(bi);
        e.bo  = (ua < ub);
        e.ovf = (r > SMAX) || (r < SMIN);
        e.d   = r[W-1:0];
`ifdef PIPE_SUB_SAT_EN
        if (e.ovf) e.d = (r > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        e.zero = (e.d == 0);
        e.neg  = e.d[W-1];
        e.tag  = tag;
        return e;
    endfunction

    // One clock: sample at negedge, then return just after the posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (rstn && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("stale_out", 1, 0);
            end else begin
                e = exp_q[0];
                chk("d", bus.d, e.d);
                chk("flags", {bus.bo, bus.ovf, bus.zero, bus.neg},
                    {e.bo, e.ovf, e.zero, e.neg});
                chk("tag", bus.out_tag, e.tag);
                if (bus.out_ready) begin
                    last_d   = bus.d;
                    last_fl  = {bus.bo, bus.ovf, bus.zero, bus.neg};
                    last_tag = bus.out_tag;
                    e = exp_q.pop_front();
                    got_n++;
                end
            end
        end
        if (rstn && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.bi, bus.in_tag));
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic bi, input logic [3:0] tag,
                           output int lat);
        int  g0;
        bit  seen;
        bus.a = a;
        bus.b = b;
        bus.bi = bi;
        bus.in_tag = tag;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("accept", acc, 1);
        bus.in_valid = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            g0 = got_n;
            step();
            if (got_n != g0) begin
                seen = 1'b1;
                lat = k;
            end
        end
    endtask

    task automatic new_beat(input logic [3:0] tag);
        bus.a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
        bus.b = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
        bus.bi = 1'($urandom_range(0, 1));
        bus.in_tag = tag;
    endtask

    initial begin
        int lat;
        int sent;
        int cyc;
        int g_start;
        logic [3:0] tcnt;

        rstn = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bi = 1'b0;
        bus.in_tag = '0;
        #3;
        chk("rst_ovalid", bus.out_valid, 0);
        chk("rst_iready", bus.in_ready, 1);
        chk("rst_d", bus.d, 0);
        chk("rst_flags", {bus.bo, bus.ovf, bus.zero, bus.neg}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        run_one(32'd5, 32'd3, 1'b0, 4'hA, lat);
        chk("t1_lat", lat, LAT);
        chk("t1_d", last_d, 32'd2);
        chk("t1_fl", last_fl, 4'b0000);
        chk("t1_tag", last_tag, 4'hA);

        run_one(32'd0, 32'd1, 1'b0, 4'h3, lat);
        chk("t2_d", last_d, 32'hFFFFFFFF);
        chk("t2_fl", last_fl, 4'b1001);
        run_one(32'd7, 32'd6, 1'b1, 4'h4, lat);
        chk("t2b_d", last_d, 32'd0);
        chk("t2b_fl", last_fl, 4'b0010);

        run_one(32'h80000000, 32'd1, 1'b0, 4'h5, lat);
`ifdef PIPE_SUB_SAT_EN
        chk("t3_d", last_d, 32'h80000000);
        chk("t3_fl", last_fl, 4'b0101);
`else
        chk("t3_d", last_d, 32'h7FFFFFFF);
        chk("t3_fl", last_fl, 4'b0100);
`endif

        run_one(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h6, lat);
`ifdef PIPE_SUB_SAT_EN
        chk("t6_d", last_d, 32'h7FFFFFFF);
        chk("t6_fl", last_fl, 4'b1100);
`else
        chk("t6_d", last_d, 32'h80000000);
        chk("t6_fl", last_fl, 4'b1101);
`endif

        // Random stream with out_ready pattern 1,0,0,1.
        g_start = got_n;
        sent = 0;
        cyc = 0;
        tcnt = 4'h0;
        new_beat(tcnt);
        while ((sent < 20 || exp_q.size() > 0) && cyc < 400) begin
            bus.in_valid = (sent < 20);
            bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            step();
            if (acc) begin
                sent++;
                tcnt++;
                new_beat(tcnt);
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("stream_sent", sent, 20);
        chk("stream_got", got_n - g_start, 20);

        // Fill four beats, stall at the output, then reset.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            new_beat(4'(8 + i));
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("fill_ovalid", bus.out_valid, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ovalid", bus.out_valid, 0);
        chk("mid_rst_iready", bus.in_ready, 1);
        exp_q.delete();
        step();
        step();
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        repeat (15) step();
        chk("no_stale", exp_q.size(), 0);
        run_one(32'd100, 32'd58, 1'b1, 4'hE, lat);
        chk("post_rst_lat", lat, LAT);
        chk("post_rst_d", last_d, 32'd41);
        chk("post_rst_tag", last_tag, 4'hE);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_subtractor.md
Name: pipe_subtractor

Overview:
- Pipelined WIDTH-bit two's-complement subtractor computing D = A - B - Bi.
- Counterpart to the team's pipelined parallel-prefix adder: the same prefix-carry structure, driven by inverted B and inverted borrow.
- Adds a valid/ready handshake, a tag sideband and result flags; feeds ALU compare and branch logic.

Parameters:
- WIDTH, 32, operand and result width; power of two, 8 to 64.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- LAT, $clog2(WIDTH)+2, pipeline depth in cycles; derived, not overridable.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  minuend (signed)
- b  in  WIDTH  subtrahend (signed)
- bi  in  1  borrow-in
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- d  out  WIDTH  difference
- bo  out  1  unsigned borrow-out (a < b+bi unsigned)
- ovf  out  1  signed overflow
- zero  out  1  d == 0
- neg  out  1  d[WIDTH-1]
- out_tag  out  TAG_W  in_tag of the matching beat

Behaviour:
- Reset is asynchronous on rstn low. All stage valids clear; all data and flag registers go to 0; out_valid=0.
- in_ready is combinational, not registered, during reset.
- Global advance: adv = out_ready | ~out_valid, and in_ready = adv. All stages shift together only when adv=1.
- Bubbles are not squeezed out. No skid buffer.
- Beat acceptance: a beat is accepted when in_valid & in_ready. It appears on the outputs exactly LAT advancing cycles later.
- Throughput is one result per cycle while out_ready stays high.
- Pipeline stages:
  - Stage 1 registers P = a ^ ~b, G = a & ~b, c0 = ~bi, plus the sign bits a[MSB] and b[MSB].
  - Stages 2 to $clog2(WIDTH)+1 are log2 prefix levels. Each level combines (G,P) pairs at span 2^k; positions not combined pass through unchanged.
  - The final stage forms the carries C[i] = G[i-1:0] | P[i-1:0] & c0, and registers d = P1 ^ C, bo = ~C[WIDTH] and the flags.
- The original P1 and sign bits are delayed alongside the prefix stages.
- Flags:
  - ovf = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]).
  - zero and neg are computed from the final d, after saturation if saturation is enabled.
- Stall: while adv=0, every stage register holds, including valid, tag and flags. Outputs stay stable, as AXI-style rules require.
- Data-register enables do not depend on valid. Only valid bits gate out_valid.
- Simultaneous stall and new input: in_ready=0, so the beat is not taken. The source must hold it.
- Reset mid-operation drops every in-flight beat. There is no partial output after rstn rises.
- Wrap-around is modulo 2^WIDTH unless the optional feature below is enabled.

Optional Feature:
- Macro: PIPE_SUB_SAT_EN.
- Defined: a signed overflow saturates d. A positive overflow (a[MSB]=0) gives 0111..1; a negative overflow gives 1000..0. ovf still reports 1, and bo is unchanged.
- Not defined: d wraps, and no saturation logic is instantiated.

Decomposition:
- Package sub_pkg:
  - WIDTH_DEF=32 and TAG_W_DEF=4.
  - Typedef sub_flags_t, a packed struct of bo, ovf, zero, neg.
  - Function clog2-based LAT computation.
- One sub-module, prefix_level: a single registered prefix level parameterized by span, with a hold enable. It is instantiated $clog2(WIDTH) times in a generate loop.

Test Plan:
- a=5, b=3, bi=0 -> after 7 cycles: d=2, bo=0, ovf=0, zero=0, neg=0, and out_tag equals in_tag.
- a=0, b=1, bi=0 -> d=0xFFFFFFFF, bo=1, neg=1, ovf=0. Then a=7, b=6, bi=1 -> d=0, zero=1, bo=0.
- a=0x80000000, b=1 -> d=0x7FFFFFFF, ovf=1. With PIPE_SUB_SAT_EN: d=0x80000000, ovf=1, neg=1.
- Stream of 20 random beats with incrementing tags while out_ready toggles 1,0,0,1: results match a reference model in order, and the outputs hold stable through every stall cycle.
- Pull rstn low with 4 beats in flight -> out_valid=0 immediately. After release, no stale beat ever appears, and the next beat has latency 7.
- a=0x7FFFFFFF, b=0xFFFFFFFF (i.e. -1) -> d=0x80000000, ovf=1, bo=1. With saturation: d=0x7FFFFFFF.
